transform_sequencer: RTL and testbench

TRANSFORM_SEQUENCER -- requirements
Module: transform_sequencer

---
 rtl/transform_sequencer.sv | 148 ++++++++++++++
 tb/tb_transform_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/transform_sequencer.sv
// Sequential 4x4 fixed-point matrix * vertex transform using one shared multiplier.
// Optional saturation of each component is enabled by defining TRANSFORM_SAT_EN.
module transform_sequencer #(
  parameter int FRAC = 8
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              matrix_load,
  input  logic [15:0][15:0] matrix_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       vtx_x,
  input  logic [15:0]       vtx_y,
  input  logic [15:0]       vtx_z,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0][15:0]  out_vec,
  output logic              out_ovf
);

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_e;

  localparam logic signed [15:0] ONE = 16'(1 << FRAC);

  // Returns {overflow, 16-bit component} for one finished row accumulator.
  function automatic logic [16:0] reduce_acc(input logic signed [31:0] acc);
`ifdef TRANSFORM_SAT_EN
    logic signed [31:0] sh;
    sh = acc >>> FRAC;
    if (sh > 32'sd32767)
      return {1'b1, 16'h7FFF};
    else if (sh < -32'sd32768)
      return {1'b1, 16'h8000};
    else
      return {1'b0, sh[15:0]};
`else
    return {1'b0, acc[FRAC+15:FRAC]};
`endif
  endfunction

  state_e             state_q;
  logic signed [15:0] mat_q [16];
  logic signed [15:0] vx_q, vy_q, vz_q;
  logic [3:0]         idx_q;
  logic               issue_done_q;
  logic signed [31:0] acc_q;
  logic [3:0][15:0]   out_vec_q;
  logic               out_valid_q;
  logic               ovf_q;

  logic signed [31:0] prod_p1_q;
  logic [3:0]         idx_p1_q;
  logic               vld_p1_q;

  logic signed [15:0] v_sel_p0;
  logic signed [31:0] mul_p0;
  logic signed [31:0] acc_d;
  logic [16:0]        red_p1;

  always_comb begin
    v_sel_p0 = ONE;
    case (idx_q[1:0])
      2'd0:    v_sel_p0 = vx_q;
      2'd1:    v_sel_p0 = vy_q;
      2'd2:    v_sel_p0 = vz_q;
      default: v_sel_p0 = ONE;
    endcase
  end

  // Stage p0: shared multiplier; stage p1: accumulate registered product.
  assign mul_p0 = mat_q[idx_q] * v_sel_p0;
  assign acc_d  = acc_q + prod_p1_q;
  assign red_p1 = reduce_acc(acc_d);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      for (int k = 0; k < 16; k++) mat_q[k] <= (k % 5 == 0) ? ONE : 16'sd0;
      vx_q         <= '0;
      vy_q         <= '0;
      vz_q         <= '0;
      idx_q        <= '0;
      issue_done_q <= 1'b0;
      acc_q        <= '0;
      out_vec_q    <= '0;
      out_valid_q  <= 1'b0;
      ovf_q        <= 1'b0;
      prod_p1_q    <= '0;
      idx_p1_q     <= '0;
      vld_p1_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (matrix_load)
            for (int k = 0; k < 16; k++) mat_q[k] <= matrix_in[k];
          if (in_valid) begin
            vx_q         <= vtx_x;
            vy_q         <= vtx_y;
            vz_q         <= vtx_z;
            acc_q        <= '0;
            idx_q        <= '0;
            ovf_q        <= 1'b0;
            issue_done_q <= 1'b0;
            vld_p1_q     <= 1'b0;
            state_q      <= MAC;
          end
        end
        MAC: begin
          if (!issue_done_q) begin
            prod_p1_q <= mul_p0;
            idx_p1_q  <= idx_q;
            vld_p1_q  <= 1'b1;
            idx_q     <= idx_q + 4'd1;
            if (idx_q == 4'd15) issue_done_q <= 1'b1;
          end else begin
            vld_p1_q <= 1'b0;
          end
          if (vld_p1_q) begin
            if (idx_p1_q[1:0] == 2'd3) begin
              out_vec_q[idx_p1_q[3:2]] <= red_p1[15:0];
              ovf_q                    <= ovf_q | red_p1[16];
              acc_q                    <= '0;
            end else begin
              acc_q <= acc_d;
            end
            if (idx_p1_q == 4'd15) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_vec   = out_vec_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_transform_sequencer.sv
// Scoreboard bench for transform_sequencer: row-by-row matrix*vector reference model,
// randomized vertices/matrices and out_ready, plus directed corner scenarios.
module tb_transform_sequencer;
  localparam int FRAC = 8;

  logic              Clk = 1'b0;
  logic              Reset_n = 1'b0;
  logic              matrix_load = 1'b0;
  logic [15:0][15:0] matrix_in = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [15:0]       vtx_x = '0, vtx_y = '0, vtx_z = '0;
  logic              out_valid;
  logic              out_ready;
  logic [3:0][15:0]  out_vec;
  logic              out_ovf;

  logic auto_rdy = 1'b0, rnd_rdy = 1'b0, man_rdy = 1'b0;
  assign out_ready = auto_rdy ? rnd_rdy : man_rdy;

  transform_sequencer #(.FRAC(FRAC)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .matrix_load(matrix_load), .matrix_in(matrix_in),
    .in_valid(in_valid), .in_ready(in_ready), .vtx_x(vtx_x), .vtx_y(vtx_y), .vtx_z(vtx_z),
    .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec), .out_ovf(out_ovf)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [3:0][15:0] vec;
    logic             ovf;
    int               due;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [15:0] mdl_mat [16];
  logic [15:0] tbm [16];
  logic [15:0] zero_m [16];

  always @(posedge Clk) cyc = cyc + 1;
  always @(negedge Clk) rnd_rdy = 1'($urandom % 2);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic void set_identity(output logic [15:0] m [16]);
    for (int k = 0; k < 16; k++) m[k] = (k % 5 == 0) ? 16'h0100 : 16'h0000;
  endfunction

  // Each component: sum over the row of signed products, 32-bit wrap, then >>> FRAC.
  function automatic exp_t model(input logic [15:0] m [16], input logic [15:0] x, y, z);
    exp_t e;
    int   v [4];
    int   acc;
    int   sh;
    v[0] = int'($signed(x));
    v[1] = int'($signed(y));
    v[2] = int'($signed(z));
    v[3] = 1 << FRAC;
    e.ovf = 1'b0;
    e.due = 0;
    e.vec = '0;
    for (int r = 0; r < 4; r++) begin
      acc = 0;
      for (int c = 0; c < 4; c++) acc += int'($signed(m[r*4+c])) * v[c];
      sh = acc >>> FRAC;
`ifdef TRANSFORM_SAT_EN
      if (sh > 32767) begin
        e.vec[r] = 16'h7FFF; e.ovf = 1'b1;
      end else if (sh < -32768) begin
        e.vec[r] = 16'h8000; e.ovf = 1'b1;
      end else begin
        e.vec[r] = sh[15:0];
      end
`else
      e.vec[r] = sh[15:0];
`endif
    end
    return e;
  endfunction

  function automatic logic [15:0] rv();
    case ($urandom % 3)
      0:       return 16'($urandom_range(0, 2047)) - 16'd1024;
      1:       return 16'($urandom);
      default: return ($urandom % 2) ? 16'h0100 : 16'hFF00;
    endcase
  endfunction

  // Offer a vertex (optionally with a same-edge matrix load); returns on the negedge after accept.
  task automatic send(input logic [15:0] x, y, z, input bit load, input logic [15:0] m [16]);
    exp_t e;
    int   n = 0;
    @(negedge Clk);
    while (!in_ready && n < 200) begin
      @(negedge Clk);
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 64'd0, 64'd1);
      return;
    end
    if (load) begin
      for (int k = 0; k < 16; k++) matrix_in[k] = m[k];
      mdl_mat = m;
      matrix_load = 1'b1;
    end
    in_valid = 1'b1;
    vtx_x = x; vtx_y = y; vtx_z = z;
    e = model(mdl_mat, x, y, z);
    e.due = cyc + 18;
    sb.push_back(e);
    @(negedge Clk);
    in_valid = 1'b0;
    matrix_load = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 100) begin
      @(negedge Clk);
      n++;
    end
    if (!out_valid) chk("out_valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic release_result();
    man_rdy = 1'b1;
    @(negedge Clk);
    man_rdy = 1'b0;
  endtask

  // Monitor: latency on the rising edge of out_valid, data on each handshake.
  logic prev_v = 1'b0;
  always @(negedge Clk) begin
    exp_t e;
    #1;
    if (!Reset_n) begin
      prev_v = 1'b0;
    end else begin
      if (out_valid && !prev_v) begin
        if (sb.size() == 0) chk("unexpected_valid", 64'd1, 64'd0);
        else chk("latency", 64'(cyc), 64'(sb[0].due));
      end
      if (out_valid && out_ready && sb.size() > 0) begin
        e = sb.pop_front();
        chk("out_vec", out_vec, e.vec);
        chk("out_ovf", 64'(out_ovf), 64'(e.ovf));
      end
      prev_v = out_valid;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0][15:0] ev;
    logic [3:0][15:0] snap_vec;
    logic             snap_ovf;
    int               n;

    for (int k = 0; k < 16; k++) zero_m[k] = 16'h0000;
    set_identity(mdl_mat);
    set_identity(tbm);

    repeat (3) @(negedge Clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_vec", out_vec, 64'd0);
    chk("rst_out_ovf", 64'(out_ovf), 64'd0);
    Reset_n = 1'b1;

    // Identity after reset, then hold the result for 5 cycles.
    send(16'h0200, 16'hFF00, 16'h0080, 1'b0, tbm);
    wait_valid();
    ev[0] = 16'h0200; ev[1] = 16'hFF00; ev[2] = 16'h0080; ev[3] = 16'h0100;
    chk("identity_vec", out_vec, ev);
    snap_vec = out_vec;
    snap_ovf = out_ovf;
    repeat (5) begin
      @(negedge Clk);
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_vec", out_vec, snap_vec);
      chk("stall_ovf", 64'(out_ovf), 64'(snap_ovf));
      chk("stall_in_ready", 64'(in_ready), 64'd0);
    end
    release_result();
    chk("idle_after_ready", 64'(in_ready), 64'd1);
    chk("valid_drop", 64'(out_valid), 64'd0);

    // Translation column, loaded on the same edge as the vertex.
    set_identity(tbm);
    tbm[3] = 16'h0300;
    send(16'h0200, 16'h0000, 16'h0000, 1'b1, tbm);
    wait_valid();
    chk("translate_x", 64'(out_vec[0]), 64'h0500);
    chk("translate_w", 64'(out_vec[3]), 64'h0100);
    release_result();

    // Row 0 overflow.
    set_identity(tbm);
    tbm[0] = 16'h7F00;
    send(16'h7F00, 16'h0000, 16'h0000, 1'b1, tbm);
    wait_valid();
`ifdef TRANSFORM_SAT_EN
    chk("ovf_x", 64'(out_vec[0]), 64'h7FFF);
    chk("ovf_flag", 64'(out_ovf), 64'd1);
`else
    chk("ovf_x", 64'(out_vec[0]), 64'h0100);
    chk("ovf_flag", 64'(out_ovf), 64'd0);
`endif
    release_result();

    // Matrix loads during MAC and DONE must be ignored.
    send(16'h0180, 16'hFE40, 16'h0033, 1'b0, tbm);
    for (int k = 0; k < 16; k++) matrix_in[k] = 16'h0000;
    matrix_load = 1'b1;
    @(negedge Clk);
    matrix_load = 1'b0;
    wait_valid();
    matrix_load = 1'b1;
    @(negedge Clk);
    matrix_load = 1'b0;
    release_result();
    send(16'h0010, 16'h0020, 16'h0030, 1'b0, tbm);
    wait_valid();
    release_result();

    // Reset in the middle of MAC.
    send(16'h1234, 16'h0567, 16'hF00D, 1'b0, tbm);
    repeat (7) @(negedge Clk);
    Reset_n = 1'b0;
    void'(sb.pop_back());
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_vec", out_vec, 64'd0);
    chk("midrst_out_ovf", 64'(out_ovf), 64'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    set_identity(mdl_mat);
    @(negedge Clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    repeat (20) @(negedge Clk);
    send(16'h0300, 16'hFD00, 16'h0040, 1'b0, tbm);
    wait_valid();
    release_result();

    // Randomized traffic with random back-pressure.
    auto_rdy = 1'b1;
    for (int i = 0; i < 30; i++) begin
      bit ld;
      ld = ($urandom % 3) == 0;
      for (int k = 0; k < 16; k++) tbm[k] = rv();
      send(rv(), rv(), rv(), ld, tbm);
    end
    n = 0;
    while (sb.size() > 0 && n < 500) begin
      @(negedge Clk);
      n++;
    end
    chk("drain_scoreboard", 64'(sb.size()), 64'd0);
    repeat (3) @(negedge Clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
